uart_frame_loader: RTL and testbench
====================================

Name: uart_frame_loader

Overview:
- Parametrised successor to the fixed 64-byte receive-to-BRAM stage.
- Sits between uart_basic's receive side (rx_data/rx_ready) and a simple dual-port BRAM write port.
- Detects a start byte, packs payload bytes into DATA_W-bit words and writes DEPTH words per frame. Supports an optional trailing checksum, an inter-byte timeout and optional double-buffering (ping-pong banks), so a reader always sees the last complete frame.

Parameters:
- START_BYTE, 8'h01, header byte that opens a frame.
- DATA_W, 8, memory word width; multiple of 8. BPW = DATA_W/8 bytes per word, little-endian (first byte in bits [7:0]).
- DEPTH, 64, words per frame; power of 2, ≥2.
- DOUBLE_BUF, 1, 1 = two banks alternating per good frame; 0 = single bank.
- CHECKSUM_EN, 1, 1 = one trailing byte equal to mod-256 sum of all payload bytes.
- TIMEOUT_CYCLES, 1_000_000, max clk cycles between bytes inside a frame; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  when low, start bytes are ignored in IDLE; a frame in progress completes normally.
- rx_data  in  8  received byte, valid when rx_ready=1.
- rx_ready  in  1  one-cycle strobe per received byte.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  AW  {bank, word_idx}. AW = $clog2(DEPTH)+DOUBLE_BUF.
- mem_din  out  DATA_W  packed word.
- busy  out  1  high from start byte accepted until return to IDLE.
- frame_done  out  1  one-cycle pulse when a frame commits.
- frame_err  out  1  one-cycle pulse on a rejected frame.
- err_code  out  2  0 none, 1 checksum, 2 timeout; held until the next frame_done or frame_err.
- rd_bank  out  1  bank holding the last good frame; tied 0 when DOUBLE_BUF=0.
- rd_valid  out  1  set at the first frame_done after reset.
- frame_count  out  16  good frames since reset; wraps at 65535→0.

Behaviour:
- Reset (async assert, sync-deassert externally assumed by clk domain): state=IDLE.
  - All outputs 0.
  - wr_bank=0, word_idx=0, byte_idx=0, checksum=0, timer=0.
- States:
  - IDLE: on rx_ready & enable & rx_data==START_BYTE → PAYLOAD, with checksum and indices cleared. All other bytes are ignored.
  - PAYLOAD: each rx_ready shifts rx_data into the packer and adds it to the checksum (8-bit wrap). On the BPW-th byte of a word:
    - next cycle: mem_we=1 for exactly one cycle, mem_addr={wr_bank,word_idx}, mem_din=packed word (latency rx_ready→mem_we = 1 clk);
    - word_idx increments.
    - After the write of word DEPTH-1: go to CHECK if CHECKSUM_EN, else COMMIT.
  - CHECK: next rx_ready compares rx_data with checksum.
    - Equal → COMMIT.
    - Unequal → frame_err=1, err_code=1, IDLE.
  - COMMIT (one cycle):
    - frame_done=1, rd_bank=wr_bank, rd_valid=1, frame_count+1, err_code=0;
    - wr_bank toggles if DOUBLE_BUF;
    - → IDLE.
- Start byte value inside PAYLOAD/CHECK is ordinary data, not a resync.
- Timeout: timer counts clk cycles in PAYLOAD/CHECK and clears on every rx_ready.
  - When timer reaches TIMEOUT_CYCLES: frame_err=1, err_code=2, IDLE.
  - wr_bank is not toggled; rd_bank/rd_valid are unchanged. The partially written bank is reused by the next frame.
  - If rx_ready arrives in the same cycle the timer would expire, the byte wins and the timer clears.
- Rejected frames never move rd_bank. With DOUBLE_BUF=1 the reader's bank is never written while rd_valid=1.
- With DOUBLE_BUF=0 the single bank is overwritten in place; rd_valid only marks that at least one good frame exists.
- enable dropping mid-frame has no effect; enable is sampled only in IDLE.
- Two rx_ready strobes are never closer than one UART byte time; the block still must accept rx_ready on consecutive cycles without loss.
- Asynchronous reset mid-frame aborts without frame_err. Any mem_we pending for the next cycle is suppressed.

Decomposition:
- Package uart_frame_pkg holds:
  - state_t enum (IDLE, PAYLOAD, CHECK, COMMIT);
  - err_code_t enum (ERR_NONE, ERR_CSUM, ERR_TIMEOUT);
  - localparam helper functions for AW and BPW.
- One sub-module: uart_word_packer (params DATA_W). Inputs byte/valid/clear. Outputs word/word_valid pulse and byte_idx.

Test Plan:
- DATA_W=8, DEPTH=4, CHECKSUM_EN=1: send 01 10 20 30 40 A0 → writes addr 0..3 = 10,20,30,40, frame_done, rd_bank=0, rd_valid=1, frame_count=1, wr_bank=1.
- Same config: send 01 10 20 30 40 A1 → frame_err, err_code=1, no frame_done, rd_valid stays 0. Next good frame writes addr 0..3 again.
- DATA_W=32, DEPTH=2, CHECKSUM_EN=0: send 01 11 22 33 44 55 66 77 88 → mem_din 32'h44332211 @0 and 32'h88776655 @1, each mem_we 1 clk after the 4th/8th byte.
- TIMEOUT_CYCLES=50: send 01 10 20, then idle 50 clk → frame_err, err_code=2, busy=0. Expiry cycle coinciding with rx_ready → no error.
- Two good frames then enable=0 with a stray 01 → rd_bank toggles 0→1, frame_count=2, third start ignored, busy stays 0.
- reset_n pulse after 2 payload bytes → all outputs 0 immediately, no frame_err. Subsequent full frame writes bank 0 from addr 0.

Source files
------------

// File: rtl/uart_frame_loader_pkg.sv
// Shared types and sizing helpers for the UART frame loader.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CHECK,
        COMMIT
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CSUM    = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_code_t;

    // Bytes packed into one memory word.
    function automatic int unsigned calc_bpw(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Memory address width: word index plus an optional bank bit.
    function automatic int unsigned calc_aw(input int unsigned depth, input int unsigned dbuf);
        return $clog2(depth) + ((dbuf != 0) ? 1 : 0);
    endfunction

    // Index width that stays at least one bit wide for a count of 1.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_loader_if.sv
// Receive-byte strobe plus BRAM write port bundled for the frame loader.
interface uart_frame_loader_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned AW     = 7
);
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DATA_W-1:0] mem_din;

    // Loader side: consumes received bytes, drives the memory write port.
    modport master (
        input  rx_data,
        input  rx_ready,
        output mem_we,
        output mem_addr,
        output mem_din
    );

    // Environment side: UART receiver and BRAM.
    modport slave (
        output rx_data,
        output rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_din
    );
endinterface

// File: rtl/uart_frame_loader_packer.sv
// Packs bytes little-endian into DATA_W-bit words; pulses word_valid the
// cycle after the last byte of a word arrives.
module uart_word_packer
    import uart_frame_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [7:0]                     data_byte,
    input  logic                           valid,
    input  logic                           clear,
    output logic [DATA_W-1:0]              word,
    output logic                           word_valid,
    output logic [idx_w(DATA_W/8)-1:0]     byte_idx
);

    localparam int unsigned BPW = calc_bpw(DATA_W);
    localparam int unsigned BIW = idx_w(BPW);
    localparam logic [BIW-1:0] LAST_IDX = BIW'(BPW - 1);

    // Byte lane write, lane index advance and word-complete pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word       <= '0;
            word_valid <= 1'b0;
            byte_idx   <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_idx <= '0;
            end else if (valid) begin
                word[{byte_idx, 3'b000} +: 8] <= data_byte;
                if (byte_idx == LAST_IDX) begin
                    byte_idx   <= '0;
                    word_valid <= 1'b1;
                end else begin
                    byte_idx <= byte_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_frame_loader.sv
// Receive-to-BRAM frame loader: start byte, DEPTH packed words, optional
// checksum byte, inter-byte timeout and optional ping-pong banks.
module uart_frame_loader
    import uart_frame_pkg::*;
#(
    parameter logic [7:0]  START_BYTE     = 8'h01,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned DEPTH          = 64,
    parameter int unsigned DOUBLE_BUF     = 1,
    parameter int unsigned CHECKSUM_EN    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    uart_frame_loader_if.master bus,
    output logic                busy,
    output logic                frame_done,
    output logic                frame_err,
    output logic [1:0]          err_code,
    output logic                rd_bank,
    output logic                rd_valid,
    output logic [15:0]         frame_count
);

    localparam int unsigned BPW = calc_bpw(DATA_W);
    localparam int unsigned AW  = calc_aw(DEPTH, DOUBLE_BUF);
    localparam int unsigned WIW = $clog2(DEPTH);
    localparam int unsigned BIW = idx_w(BPW);
    localparam logic [BIW-1:0] LAST_BYTE  = BIW'(BPW - 1);
    localparam logic [WIW-1:0] LAST_WORD  = WIW'(DEPTH - 1);
    localparam bit             TIMEOUT_ON = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0]    TIMER_LAST = TIMEOUT_ON ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    state_t            state;
    err_code_t         err_r;
    logic              wr_bank;
    logic [WIW-1:0]    word_idx;
    logic [7:0]        checksum;
    logic [31:0]       timer;
    logic [AW-1:0]     addr_r;

    logic [DATA_W-1:0] pk_word;
    logic              pk_valid;
    logic [BIW-1:0]    pk_idx;

    logic              start_hit;
    logic              pk_clear;
    logic              pay_byte;
    logic              word_end;
    logic              timed_out;
    logic              commit_now;
    logic              fail_now;
    err_code_t         fail_code;

    assign start_hit = bus.rx_ready && enable && (bus.rx_data == START_BYTE);
    assign pk_clear  = ((state == IDLE) || (state == COMMIT)) && start_hit;
    assign pay_byte  = bus.rx_ready && (state == PAYLOAD);
    assign word_end  = pay_byte && (pk_idx == LAST_BYTE);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign timed_out = TIMEOUT_ON && ((state == PAYLOAD) || (state == CHECK)) &&
                       !bus.rx_ready && (timer == TIMER_LAST);

    uart_word_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_byte  (bus.rx_data),
        .valid      (pay_byte),
        .clear      (pk_clear),
        .word       (pk_word),
        .word_valid (pk_valid),
        .byte_idx   (pk_idx)
    );

    assign bus.mem_we   = pk_valid;
    assign bus.mem_din  = pk_word;
    assign bus.mem_addr = addr_r;
    assign err_code     = err_r;

    // Frame-level outcome of this cycle: commit or reject.
    always_comb begin
        commit_now = 1'b0;
        fail_now   = 1'b0;
        fail_code  = ERR_NONE;
        case (state)
            PAYLOAD: begin
                if (word_end && (word_idx == LAST_WORD) && (CHECKSUM_EN == 0)) begin
                    commit_now = 1'b1;
                end else if (timed_out) begin
                    fail_now  = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            CHECK: begin
                if (bus.rx_ready) begin
                    if (bus.rx_data == checksum) begin
                        commit_now = 1'b1;
                    end else begin
                        fail_now  = 1'b1;
                        fail_code = ERR_CSUM;
                    end
                end else if (timed_out) begin
                    fail_now  = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    // Frame FSM with registered status outputs; commit/reject actions are
    // applied after the per-state datapath so they take precedence.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            err_r       <= ERR_NONE;
            wr_bank     <= 1'b0;
            word_idx    <= '0;
            checksum    <= '0;
            timer       <= '0;
            addr_r      <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            rd_bank     <= 1'b0;
            rd_valid    <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                // COMMIT lasts one cycle but still honours a start byte so
                // back-to-back frames are not lost.
                IDLE, COMMIT: begin
                    timer <= '0;
                    if (start_hit) begin
                        state    <= PAYLOAD;
                        busy     <= 1'b1;
                        word_idx <= '0;
                        checksum <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                PAYLOAD: begin
                    if (bus.rx_ready) begin
                        timer    <= '0;
                        checksum <= checksum + bus.rx_data;
                        if (word_end) begin
                            addr_r   <= AW'({wr_bank, word_idx});
                            word_idx <= word_idx + 1'b1;
                            if ((word_idx == LAST_WORD) && (CHECKSUM_EN != 0)) begin
                                state <= CHECK;
                            end
                        end
                    end else if (TIMEOUT_ON) begin
                        timer <= timer + 1'b1;
                    end
                end
                CHECK: begin
                    if (bus.rx_ready) begin
                        timer <= '0;
                    end else if (TIMEOUT_ON) begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (commit_now) begin
                state       <= COMMIT;
                frame_done  <= 1'b1;
                rd_bank     <= wr_bank;
                rd_valid    <= 1'b1;
                frame_count <= frame_count + 1'b1;
                err_r       <= ERR_NONE;
                if (DOUBLE_BUF != 0) begin
                    wr_bank <= ~wr_bank;
                end
            end

            if (fail_now) begin
                state     <= IDLE;
                busy      <= 1'b0;
                frame_err <= 1'b1;
                err_r     <= fail_code;
                timer     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader: two configurations, scoreboarded
// BRAM writes with exact write-cycle expectations.
module tb_uart_frame_loader;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] din;
        int unsigned cyc;
    } wr_t;

    logic        clk = 1'b0;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: byte words, 4 deep, checksum, ping-pong, 50-cycle timeout.
    logic        a_rst_n = 1'b1;
    logic        a_enable = 1'b1;
    logic        a_busy, a_frame_done, a_frame_err, a_rd_bank, a_rd_valid;
    logic [1:0]  a_err_code;
    logic [15:0] a_frame_count;
    uart_frame_loader_if #(.DATA_W(8), .AW(3)) a_bus ();

    uart_frame_loader #(
        .START_BYTE     (8'h01),
        .DATA_W         (8),
        .DEPTH          (4),
        .DOUBLE_BUF     (1),
        .CHECKSUM_EN    (1),
        .TIMEOUT_CYCLES (50)
    ) u_a (
        .clk         (clk),
        .reset_n     (a_rst_n),
        .enable      (a_enable),
        .bus         (a_bus),
        .busy        (a_busy),
        .frame_done  (a_frame_done),
        .frame_err   (a_frame_err),
        .err_code    (a_err_code),
        .rd_bank     (a_rd_bank),
        .rd_valid    (a_rd_valid),
        .frame_count (a_frame_count)
    );

    // DUT B: 32-bit words, 2 deep, no checksum, single bank, no timeout.
    logic        b_rst_n = 1'b1;
    logic        b_enable = 1'b1;
    logic        b_busy, b_frame_done, b_frame_err, b_rd_bank, b_rd_valid;
    logic [1:0]  b_err_code;
    logic [15:0] b_frame_count;
    uart_frame_loader_if #(.DATA_W(32), .AW(1)) b_bus ();

    uart_frame_loader #(
        .START_BYTE     (8'h01),
        .DATA_W         (32),
        .DEPTH          (2),
        .DOUBLE_BUF     (0),
        .CHECKSUM_EN    (0),
        .TIMEOUT_CYCLES (0)
    ) u_b (
        .clk         (clk),
        .reset_n     (b_rst_n),
        .enable      (b_enable),
        .bus         (b_bus),
        .busy        (b_busy),
        .frame_done  (b_frame_done),
        .frame_err   (b_frame_err),
        .err_code    (b_err_code),
        .rd_bank     (b_rd_bank),
        .rd_valid    (b_rd_valid),
        .frame_count (b_frame_count)
    );

    wr_t         qa[$];
    wr_t         qb[$];
    int unsigned a_done_cnt = 0, a_err_cnt = 0, a_err_cyc = 0;
    int unsigned b_done_cnt = 0, b_err_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitors: every mem_we must match the head of the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (a_bus.mem_we === 1'b1) begin
            chk("a_we_expected", 64'(qa.size() != 0), 64'd1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("a_addr", 64'(a_bus.mem_addr), 64'(e.addr));
                chk("a_din", 64'(a_bus.mem_din), 64'(e.din));
                chk("a_we_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (a_frame_done === 1'b1) a_done_cnt++;
        if (a_frame_err === 1'b1) begin
            a_err_cnt++;
            a_err_cyc = cyc;
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (b_bus.mem_we === 1'b1) begin
            chk("b_we_expected", 64'(qb.size() != 0), 64'd1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("b_addr", 64'(b_bus.mem_addr), 64'(e.addr));
                chk("b_din", 64'(b_bus.mem_din), 64'(e.din));
                chk("b_we_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (b_frame_done === 1'b1) b_done_cnt++;
        if (b_frame_err === 1'b1) b_err_cnt++;
    end

    // One byte to A followed by one idle cycle; returns just after the
    // sampling edge.
    task automatic a_byte(input logic [7:0] b, input bit exp_wr, input logic [5:0] addr);
        @(negedge clk);
        if (exp_wr) qa.push_back('{addr, {24'd0, b}, cyc + 1});
        a_bus.rx_data  = b;
        a_bus.rx_ready = 1'b1;
        @(negedge clk);
        a_bus.rx_ready = 1'b0;
    endtask

    task automatic a_frame(input logic [31:0] pl, input logic [7:0] cs, input logic [5:0] base);
        logic [7:0] b;
        a_byte(8'h01, 1'b0, 6'd0);
        for (int i = 0; i < 4; i++) begin
            b = pl[i*8 +: 8];
            a_byte(b, 1'b1, base + 6'(i));
        end
        a_byte(cs, 1'b0, 6'd0);
        #1;
    endtask

    // One byte to B held into the next cycle (back-to-back capable).
    task automatic b_byte(input logic [7:0] b, input bit exp_wr, input logic [5:0] addr, input logic [31:0] din);
        @(negedge clk);
        if (exp_wr) qb.push_back('{addr, din, cyc + 1});
        b_bus.rx_data  = b;
        b_bus.rx_ready = 1'b1;
    endtask

    task automatic b_stop();
        @(negedge clk);
        b_bus.rx_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c;
        a_bus.rx_data = 8'h00; a_bus.rx_ready = 1'b0;
        b_bus.rx_data = 8'h00; b_bus.rx_ready = 1'b0;
        #3;
        a_rst_n = 1'b0;
        b_rst_n = 1'b0;
        #1;
        chk("a_rst_busy", 64'(a_busy), 64'd0);
        chk("a_rst_done", 64'(a_frame_done), 64'd0);
        chk("a_rst_err", 64'(a_frame_err), 64'd0);
        chk("a_rst_err_code", 64'(a_err_code), 64'd0);
        chk("a_rst_rd_bank", 64'(a_rd_bank), 64'd0);
        chk("a_rst_rd_valid", 64'(a_rd_valid), 64'd0);
        chk("a_rst_count", 64'(a_frame_count), 64'd0);
        chk("a_rst_we", 64'(a_bus.mem_we), 64'd0);
        chk("a_rst_addr", 64'(a_bus.mem_addr), 64'd0);
        chk("a_rst_din", 64'(a_bus.mem_din), 64'd0);
        chk("b_rst_busy", 64'(b_busy), 64'd0);
        chk("b_rst_count", 64'(b_frame_count), 64'd0);
        repeat (2) @(negedge clk);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;

        // B: 32-bit little-endian packing, bytes back to back.
        b_byte(8'h01, 1'b0, 6'd0, 32'd0);
        b_byte(8'h11, 1'b0, 6'd0, 32'd0);
        b_byte(8'h22, 1'b0, 6'd0, 32'd0);
        b_byte(8'h33, 1'b0, 6'd0, 32'd0);
        b_byte(8'h44, 1'b1, 6'd0, 32'h44332211);
        b_byte(8'h55, 1'b0, 6'd0, 32'd0);
        b_byte(8'h66, 1'b0, 6'd0, 32'd0);
        b_byte(8'h77, 1'b0, 6'd0, 32'd0);
        b_byte(8'h88, 1'b1, 6'd1, 32'h88776655);
        b_stop();
        #1;
        chk("b1_done_cnt", 64'(b_done_cnt), 64'd1);
        chk("b1_rd_valid", 64'(b_rd_valid), 64'd1);
        chk("b1_rd_bank", 64'(b_rd_bank), 64'd0);
        chk("b1_count", 64'(b_frame_count), 64'd1);
        @(negedge clk); #1;
        chk("b1_busy_after", 64'(b_busy), 64'd0);

        // B: start value inside payload is data; long gap with timeout off.
        b_byte(8'h01, 1'b0, 6'd0, 32'd0); b_stop();
        b_byte(8'h01, 1'b0, 6'd0, 32'd0); b_stop();
        b_byte(8'h02, 1'b0, 6'd0, 32'd0); b_stop();
        repeat (200) @(negedge clk);
        chk("b2_busy_gap", 64'(b_busy), 64'd1);
        b_byte(8'h03, 1'b0, 6'd0, 32'd0);
        b_byte(8'h04, 1'b1, 6'd0, 32'h04030201); b_stop();
        b_byte(8'h05, 1'b0, 6'd0, 32'd0);
        b_byte(8'h06, 1'b0, 6'd0, 32'd0);
        b_byte(8'h07, 1'b0, 6'd0, 32'd0);
        b_byte(8'h08, 1'b1, 6'd1, 32'h08070605);
        b_stop();
        #1;
        chk("b2_done_cnt", 64'(b_done_cnt), 64'd2);
        chk("b2_err_cnt", 64'(b_err_cnt), 64'd0);
        chk("b2_count", 64'(b_frame_count), 64'd2);
        chk("b2_rd_bank", 64'(b_rd_bank), 64'd0);

        // A: bad checksum rejects, bank 0 reused afterwards.
        a_frame(32'h40302010, 8'hA1, 6'd0);
        chk("a_bad_err_cnt", 64'(a_err_cnt), 64'd1);
        chk("a_bad_err_code", 64'(a_err_code), 64'd1);
        chk("a_bad_done_cnt", 64'(a_done_cnt), 64'd0);
        chk("a_bad_rd_valid", 64'(a_rd_valid), 64'd0);
        chk("a_bad_busy", 64'(a_busy), 64'd0);

        // A: good frame into bank 0, then a good frame into bank 1.
        a_frame(32'h40302010, 8'hA0, 6'd0);
        chk("a_g1_done_cnt", 64'(a_done_cnt), 64'd1);
        chk("a_g1_rd_bank", 64'(a_rd_bank), 64'd0);
        chk("a_g1_rd_valid", 64'(a_rd_valid), 64'd1);
        chk("a_g1_count", 64'(a_frame_count), 64'd1);
        chk("a_g1_err_code", 64'(a_err_code), 64'd0);
        a_frame(32'h08070605, 8'h1A, 6'd4);
        chk("a_g2_done_cnt", 64'(a_done_cnt), 64'd2);
        chk("a_g2_rd_bank", 64'(a_rd_bank), 64'd1);
        chk("a_g2_count", 64'(a_frame_count), 64'd2);

        // A: start byte ignored while disabled in IDLE.
        a_enable = 1'b0;
        a_byte(8'h01, 1'b0, 6'd0);
        #1;
        chk("a_dis_busy", 64'(a_busy), 64'd0);
        a_byte(8'h10, 1'b0, 6'd0);
        a_byte(8'h20, 1'b0, 6'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("a_dis_busy2", 64'(a_busy), 64'd0);
        chk("a_dis_count", 64'(a_frame_count), 64'd2);
        a_enable = 1'b1;

        // A: timeout exactly 50 cycles after the last byte.
        a_byte(8'h01, 1'b0, 6'd0);
        a_byte(8'h10, 1'b1, 6'd0);
        a_byte(8'h20, 1'b1, 6'd1);
        c = cyc;
        repeat (60) @(negedge clk);
        #1;
        chk("a_to_err_cnt", 64'(a_err_cnt), 64'd2);
        chk("a_to_err_cyc", 64'(a_err_cyc), 64'(c + 50));
        chk("a_to_err_code", 64'(a_err_code), 64'd2);
        chk("a_to_busy", 64'(a_busy), 64'd0);
        chk("a_to_rd_bank", 64'(a_rd_bank), 64'd1);
        chk("a_to_rd_valid", 64'(a_rd_valid), 64'd1);
        chk("a_to_count", 64'(a_frame_count), 64'd2);

        // A: byte landing on the expiry cycle keeps the frame alive.
        a_byte(8'h01, 1'b0, 6'd0);
        a_byte(8'h10, 1'b1, 6'd0);
        repeat (48) @(negedge clk);
        a_byte(8'h20, 1'b1, 6'd1);
        a_byte(8'h30, 1'b1, 6'd2);
        a_byte(8'h40, 1'b1, 6'd3);
        a_byte(8'hA0, 1'b0, 6'd0);
        #1;
        chk("a_edge_err_cnt", 64'(a_err_cnt), 64'd2);
        chk("a_edge_done_cnt", 64'(a_done_cnt), 64'd3);
        chk("a_edge_rd_bank", 64'(a_rd_bank), 64'd0);
        chk("a_edge_count", 64'(a_frame_count), 64'd3);
        chk("a_edge_err_code", 64'(a_err_code), 64'd0);

        // A: reset mid-frame with a write pending for the next cycle.
        a_byte(8'h01, 1'b0, 6'd0);
        a_byte(8'h10, 1'b1, 6'd4);
        @(negedge clk);
        a_bus.rx_data  = 8'h20;
        a_bus.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        a_rst_n = 1'b0;
        #1;
        a_bus.rx_ready = 1'b0;
        chk("a_mid_we", 64'(a_bus.mem_we), 64'd0);
        chk("a_mid_busy", 64'(a_busy), 64'd0);
        chk("a_mid_count", 64'(a_frame_count), 64'd0);
        chk("a_mid_rd_valid", 64'(a_rd_valid), 64'd0);
        chk("a_mid_err_code", 64'(a_err_code), 64'd0);
        repeat (2) @(negedge clk);
        a_rst_n = 1'b1;
        chk("a_mid_err_cnt", 64'(a_err_cnt), 64'd2);

        // A: fresh frame after reset lands in bank 0; enable drop mid-frame
        // has no effect.
        a_byte(8'h01, 1'b0, 6'd0);
        a_enable = 1'b0;
        a_byte(8'h11, 1'b1, 6'd0);
        a_byte(8'h22, 1'b1, 6'd1);
        a_byte(8'h33, 1'b1, 6'd2);
        a_byte(8'h44, 1'b1, 6'd3);
        a_byte(8'hAA, 1'b0, 6'd0);
        #1;
        a_enable = 1'b1;
        chk("a_post_done_cnt", 64'(a_done_cnt), 64'd4);
        chk("a_post_rd_bank", 64'(a_rd_bank), 64'd0);
        chk("a_post_rd_valid", 64'(a_rd_valid), 64'd1);
        chk("a_post_count", 64'(a_frame_count), 64'd1);

        repeat (3) @(negedge clk);
        chk("a_queue_empty", 64'(qa.size()), 64'd0);
        chk("b_queue_empty", 64'(qb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
